// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver, mid-bit sampling at BAUD_DIV clocks per bit.
// Recovers bytes from the matching transmitter's serial line and hands them
// to a consumer through a single holding register with overrun and
// framing-error pulses.
//
// Consumer handshake: rx_valid is a level that is high while rx_data holds a
// byte the consumer has not yet taken. The consumer takes it by raising
// rx_ack in any cycle where rx_valid=1; rx_valid drops on the following edge.
// rx_ack while rx_valid=0 has no effect. When a new good byte lands in the
// same cycle as an ack, the new byte wins: rx_valid stays 1 and no overrun
// is flagged. A new good byte while rx_valid=1 and no ack overwrites rx_data
// and pulses overrun for one clock.
module uart_rx_oversampled #(
  parameter int BAUD_DIV = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  // Sample points inside a bit, as baud-counter values.
  localparam logic [7:0] MID_CNT  = 8'(BAUD_DIV / 2 - 1);
  localparam logic [7:0] LAST_CNT = 8'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    S_WAIT_IDLE = 3'd0,
    S_IDLE      = 3'd1,
    S_START     = 3'd2,
    S_DATA      = 3'd3,
    S_STOP      = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;
  logic        rx_meta_q, rxs_q;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
    end
  end

  // State, counters, shift register and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_WAIT_IDLE;
      cnt_q   <= 8'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  // Frame sequencing and the holding-register handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    // Ack consumes the held byte; a byte completing this cycle overrides below.
    if (valid_q && rx_ack) begin
      valid_d = 1'b0;
    end

    case (state_q)
      // Wait for the line to go high so a held-low line or a frame caught
      // mid-way is never mistaken for a start bit.
      S_WAIT_IDLE: begin
        cnt_d = 8'd0;
        if (rxs_q) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        cnt_d = 8'd0;
        if (!rxs_q) begin
          state_d = S_START;
        end
      end
      // Re-check the start bit halfway through; a high line here was a glitch.
      S_START: begin
        if (cnt_q == MID_CNT) begin
          cnt_d = 8'd0;
          if (!rxs_q) begin
            state_d = S_DATA;
            bit_d   = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      // Counting from mid-start, every BAUD_DIV clocks lands mid-bit.
      S_DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d          = 8'd0;
          shift_d[bit_q] = rxs_q;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      // Returning to IDLE at mid-stop leaves half a bit to spot the next start.
      S_STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = 8'd0;
          if (rxs_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            ovr_d   = valid_q && !rx_ack;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_WAIT_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q == S_START) || (state_q == S_DATA) ||
                     (state_q == S_STOP);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled at BAUD_DIV=4.
// Frames are driven one clock step at a time just after the rising edge; with
// that alignment the stop-bit sample happens on the 41st edge after the start
// bit begins, so each good byte is visible one step after the frame ends.
module tb_uart_rx_oversampled;

  localparam int BAUD_DIV = 4;

  logic       clk;
  logic       reset_n;
  logic       rx;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_vec;
  int n_err;
  int fe_cnt;
  int ov_cnt;

  uart_rx_oversampled #(.BAUD_DIV(BAUD_DIV)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx        (rx),
    .rx_ack    (rx_ack),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  // Clock and pulse counters (sampled on the falling edge).
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun)   ov_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BAUD_DIV) step();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_bit);
  endtask

  // One step after a good frame: byte held, no framing error.
  task automatic expect_byte(input string tag, input logic [7:0] d,
                             input logic ovr);
    step();
    check({tag, "_valid"}, rx_valid, 1);
    check({tag, "_data"}, rx_data, d);
    check({tag, "_ferr"}, frame_err, 0);
    check({tag, "_ovr"}, overrun, ovr);
  endtask

  task automatic ack_byte();
    rx_ack = 1'b1;
    step();
    rx_ack = 1'b0;
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    fe_cnt  = 0;
    ov_cnt  = 0;
    rx      = 1'b1;
    rx_ack  = 1'b0;
    reset_n = 1'b0;

    // Reset values.
    repeat (2) step();
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    reset_n = 1'b1;
    repeat (4) step();

    // Single frame and ack.
    send_frame(8'hA5, 1'b1);
    expect_byte("a5", 8'hA5, 1'b0);
    ack_byte();
    check("a5_ack_valid", rx_valid, 0);
    check("a5_ack_data", rx_data, 8'hA5);
    repeat (4) step();

    // Back-to-back frames without ack: second one overruns.
    send_frame(8'h3C, 1'b1);
    fork
      send_frame(8'hC3, 1'b1);
      begin
        step();
        check("b2b_first_valid", rx_valid, 1);
        check("b2b_first_data", rx_data, 8'h3C);
      end
    join
    expect_byte("b2b_second", 8'hC3, 1'b1);
    step();
    check("b2b_ovr_single", overrun, 0);
    check("b2b_ovr_cnt", ov_cnt, 1);
    ack_byte();
    check("b2b_ack_valid", rx_valid, 0);

    // Back-to-back with ack landing on the second completion: no overrun.
    send_frame(8'h3C, 1'b1);
    fork
      send_frame(8'hC3, 1'b1);
      begin
        step();
        check("coack_first_data", rx_data, 8'h3C);
      end
    join
    rx_ack = 1'b1;
    step();
    rx_ack = 1'b0;
    check("coack_valid", rx_valid, 1);
    check("coack_data", rx_data, 8'hC3);
    check("coack_ovr", overrun, 0);
    step();
    check("coack_ovr_cnt", ov_cnt, 1);
    ack_byte();
    repeat (4) step();

    // One-clock glitch: START aborts back to IDLE.
    rx = 1'b0;
    step();
    rx = 1'b1;
    repeat (2) step();
    check("glitch_busy_start", busy, 1);
    repeat (2) step();
    check("glitch_busy_end", busy, 0);
    repeat (4) step();
    check("glitch_valid", rx_valid, 0);
    check("glitch_fe_cnt", fe_cnt, 0);
    send_frame(8'h55, 1'b1);
    expect_byte("g55", 8'h55, 1'b0);
    repeat (4) step();

    // Bad stop bit, line then held low: one frame_err, held byte untouched.
    begin
      logic busy_seen;
      send_frame(8'h0F, 1'b0);
      step();
      check("fe_pulse", frame_err, 1);
      check("fe_valid", rx_valid, 1);
      check("fe_data", rx_data, 8'h55);
      check("fe_busy", busy, 0);
      busy_seen = 1'b0;
      repeat (19) begin
        step();
        if (busy) busy_seen = 1'b1;
      end
      check("fe_low_no_start", busy_seen, 0);
      check("fe_cnt", fe_cnt, 1);
      rx = 1'b1;
      repeat (4) step();
      ack_byte();
      check("fe_ack_valid", rx_valid, 0);
      send_frame(8'h81, 1'b1);
      expect_byte("fe81", 8'h81, 1'b0);
      repeat (4) step();
    end

    // Reset during data bit 3 of a 0xF0 frame, released while the line is
    // high in bit 4; the rest of the frame stays high so nothing is reported.
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b0);
    rx = 1'b0;
    repeat (2) step();
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", rx_valid, 0);
    check("mid_rst_data", rx_data, 8'h00);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ferr", frame_err, 0);
    check("mid_rst_ovr", overrun, 0);
    repeat (2) step();
    rx = 1'b1;
    repeat (2) step();
    reset_n = 1'b1;
    repeat (2) step();
    for (int i = 5; i < 8; i++) drive_bit(1'b1);
    drive_bit(1'b1);
    repeat (8) step();
    check("post_rst_valid", rx_valid, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_fe_cnt", fe_cnt, 1);
    send_frame(8'h7E, 1'b1);
    expect_byte("rst7e", 8'h7E, 1'b0);
    ack_byte();
    repeat (4) step();

    // Transmitter-style stream: 0x00, one idle bit, then 0xFF.
    send_frame(8'h00, 1'b1);
    expect_byte("lb00", 8'h00, 1'b0);
    ack_byte();
    repeat (2) step();
    send_frame(8'hFF, 1'b1);
    expect_byte("lbff", 8'hFF, 1'b0);
    repeat (4) step();
    check("final_fe_cnt", fe_cnt, 1);
    check("final_ov_cnt", ov_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_oversampled.md
Name: uart_rx_oversampled

Overview:
- Serial receiver that sits directly downstream of the team's UART transmitter.
- Consumes the transmitter's serial line and recovers 8N1 frames: 1 start bit (0), 8 data bits LSB-first, 1 stop bit (1).
- Each bit lasts BAUD_DIV clocks, matching the transmitter's bit period.
- Samples mid-bit, validates the start and stop bits, and presents each byte through a valid/ack holding register with framing-error and overrun flags.

Parameters:
- BAUD_DIV, 4, clocks per serial bit; legal range 2..256; must equal the transmitter's BAUD_DIV.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- rx  input  1  serial line; idles high; asynchronous to clk.
- rx_ack  input  1  consumer acknowledge; clears rx_valid.
- rx_data  output  8  last received byte; holds until overwritten by the next good frame.
- rx_valid  output  1  level; high while rx_data holds an unacknowledged byte.
- frame_err  output  1  one-cycle pulse when the stop-bit sample is 0.
- overrun  output  1  one-cycle pulse when a good byte arrives while rx_valid=1 and rx_ack=0.
- busy  output  1  high in START, DATA and STOP.

Behaviour:
- Synchronizer:
  - rx passes through a 2-flop synchronizer; both flops reset to 1.
  - All decisions use the synchronized value, called rxs.
  - Input-to-decision latency is 2 clocks.
- Reset values, applied asynchronously while reset_n=0:
  - rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - Baud counter=0, bit index=0, state=WAIT_IDLE.
- Counters:
  - Baud counter is 8 bits and bit index is 3 bits.
  - The baud counter restarts at 0 on every state entry.
- WAIT_IDLE:
  - Stay while rxs=0.
  - On rxs=1, go to IDLE.
  - This stops a line held low, or a frame caught mid-way when reset releases, from being taken as a start bit.
- IDLE:
  - On rxs=0, go to START with baud counter=0.
- START:
  - Counter increments each clock.
  - At count == BAUD_DIV/2 - 1 (integer division), sample rxs.
  - rxs=0: go to DATA, counter=0, bit index=0.
  - rxs=1: false start (glitch); go to IDLE with no flags raised.
- DATA:
  - At count == BAUD_DIV-1, shift rxs into bit position [bit index] and reset the counter.
  - After bit index 7 is sampled, go to STOP; otherwise increment bit index.
- STOP:
  - At count == BAUD_DIV-1, sample rxs.
  - rxs=1 (good frame):
    - rx_data is loaded and rx_valid=1 on the next clock edge.
    - If rx_valid was 1 and rx_ack=0 that cycle, overrun pulses for 1 clock and rx_data is overwritten with the new byte.
    - Go to IDLE.
  - rxs=0:
    - frame_err pulses for 1 clock.
    - rx_data and rx_valid are unchanged.
    - Go to WAIT_IDLE (covers break conditions).
- Handshake:
  - rx_ack while rx_valid=1 clears rx_valid on the next clock.
  - rx_ack while rx_valid=0 is ignored.
  - rx_ack in the same cycle a good byte completes: rx_valid stays 1 with the new data, no overrun.
- Latency: rx_valid rises on the clock after the stop-bit sample, i.e. about 9.5·BAUD_DIV + 3 clocks after the rx falling edge.
- Back-to-back frames:
  - The receiver returns to IDLE on the stop sample.
  - It is therefore ready for a start bit arriving BAUD_DIV/2 clocks later.
  - This covers consecutive transmitter frames, including the transmitter's idle gap.
- rx_ack, overrun and frame_err never affect state-machine sequencing.

Test Plan:
- BAUD_DIV=4, drive an 8N1 frame of 0xA5 with 4-clock bits -> rx_valid=1, rx_data=8'hA5, frame_err=0, overrun=0; pulse rx_ack -> rx_valid=0 next clock.
- Two back-to-back frames 0x3C then 0xC3, no ack -> first rx_data=0x3C; after the second frame rx_data=0xC3 plus a single overrun pulse; repeat with rx_ack coincident with the second completion -> no overrun, rx_valid stays 1.
- rx low for 1 clock only (glitch) -> START aborts to IDLE, busy returns to 0, no rx_valid or frame_err; a following 0x55 frame is received correctly.
- Frame 0x0F with stop bit driven 0 and the line held low for 20 clocks -> frame_err pulses once, rx_valid unchanged, busy=0 and no new start detected until rx returns high; the next 0x81 frame is received.
- Assert reset_n=0 during data bit 3 of a frame, release while rx is still mid-frame -> outputs at reset values; no byte is reported from the partial frame; the next full frame 0x7E is received correctly.
- Loopback with the transmitter (shared clk, BAUD_DIV=4, 0x00 then 0xFF) -> rx_data matches each byte, with no error flags.
